mem_arbiter_mc: RTL and testbench

MEM_ARBITER_MC -- requirements
Module: mem_arbiter_mc

---
 rtl/mem_arbiter_mc.sv | 104 ++++++++++
 tb/tb_mem_arbiter_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_mc.sv
// Two-port memory arbiter. The core has fixed priority; the ext port wins after
// MaxCoreRun back-to-back core grants that it has waited through. Reads return one cycle later.
module mem_arbiter_mc #(
   parameter int XLen       = 32,
   parameter int MaxCoreRun = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            core_req_i,
   input  logic            core_we_i,
   input  logic [XLen-1:0] core_addr_i,
   input  logic [XLen-1:0] core_wdata_i,
   output logic            core_gnt_o,
   output logic            core_stall_o,
   output logic            core_rvalid_o,
   output logic [XLen-1:0] core_rdata_o,

   input  logic            ext_req_i,
   input  logic            ext_we_i,
   input  logic [XLen-1:0] ext_addr_i,
   input  logic [XLen-1:0] ext_wdata_i,
   output logic            ext_gnt_o,
   output logic            ext_rvalid_o,
   output logic [XLen-1:0] ext_rdata_o,

   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLen-1:0] mem_addr_o,
   output logic [XLen-1:0] mem_wdata_o,
   input  logic [XLen-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      OwnNone,
      OwnCore,
      OwnExt
   } owner_e;

   localparam logic [3:0] RunMax = 4'(MaxCoreRun);

   owner_e     owner;
   logic [3:0] run_cnt;
   logic       ext_turn;
   logic       core_sel;
   logic       ext_sel;

   // Grants are masked while reset is held so nothing reaches memory during reset.
   always_comb begin
      ext_turn = ext_req_i && (run_cnt == RunMax);
      core_sel = rst_ni && core_req_i && !ext_turn;
      ext_sel  = rst_ni && ext_req_i && !core_sel;
   end

   assign core_gnt_o   = core_sel;
   assign ext_gnt_o    = ext_sel;
   assign core_stall_o = core_req_i && !core_sel;

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (core_sel) begin
         mem_req_o   = 1'b1;
         mem_we_o    = core_we_i;
         mem_addr_o  = core_addr_i;
         mem_wdata_o = core_wdata_i;
      end else if (ext_sel) begin
         mem_req_o   = 1'b1;
         mem_we_o    = ext_we_i;
         mem_addr_o  = ext_addr_i;
         mem_wdata_o = ext_wdata_i;
      end
   end

   // run_cnt only counts core grants that the ext port sat through.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_cnt <= 4'd0;
         owner   <= OwnNone;
      end else begin
         if (!ext_req_i || ext_sel) begin
            run_cnt <= 4'd0;
         end else if (core_sel && (run_cnt != RunMax)) begin
            run_cnt <= run_cnt + 4'd1;
         end

         if (core_sel && !core_we_i) begin
            owner <= OwnCore;
         end else if (ext_sel && !ext_we_i) begin
            owner <= OwnExt;
         end else begin
            owner <= OwnNone;
         end
      end
   end

   assign core_rvalid_o = (owner == OwnCore);
   assign ext_rvalid_o  = (owner == OwnExt);
   assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
   assign ext_rdata_o   = ext_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Bench for mem_arbiter_mc: directed scenarios then random traffic, all checked
// against a fairness/latency reference model and a shadow copy of memory.
module tb_mem_arbiter_mc;

   localparam int XLen   = 32;
   localparam int MaxRun = 4;

   logic            clk;
   logic            rst_ni;
   logic            core_req, core_we;
   logic [XLen-1:0] core_addr, core_wdata;
   logic            core_gnt, core_stall, core_rvalid;
   logic [XLen-1:0] core_rdata;
   logic            ext_req, ext_we;
   logic [XLen-1:0] ext_addr, ext_wdata;
   logic            ext_gnt, ext_rvalid;
   logic [XLen-1:0] ext_rdata;
   logic            mem_req, mem_we;
   logic [XLen-1:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   // reference model state
   int              streak;
   bit              pend_core, pend_ext;
   logic [XLen-1:0] pend_data;
   logic [XLen-1:0] ref_mem [16];
   logic [XLen-1:0] env_mem [16];
   bit              last_cg, last_eg;

   mem_arbiter_mc #(.XLen(XLen), .MaxCoreRun(MaxRun)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
      .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_stall_o(core_stall),
      .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
      .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
      .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
      .ext_rdata_o(ext_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory; when not read it returns noise so ungated rdata shows up.
   always @(posedge clk) begin
      if (mem_req && mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;
      if (mem_req && !mem_we) mem_rdata <= env_mem[mem_addr[5:2]];
      else mem_rdata <= $urandom;
   end

   task automatic chk(input string tag, input logic [XLen-1:0] obs, input logic [XLen-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Checks outputs for the current inputs, assuming the DUT is out of reset.
   task automatic check_cycle();
      bit ext_turn, e_cg, e_eg;
      logic e_we;
      logic [XLen-1:0] e_addr, e_wdata;
      @(negedge clk);
      #1;
      ext_turn = ext_req && (streak >= MaxRun);
      e_cg = core_req && !ext_turn;
      e_eg = ext_req && !e_cg;
      e_we    = e_cg ? core_we    : (e_eg ? ext_we    : 1'b0);
      e_addr  = e_cg ? core_addr  : (e_eg ? ext_addr  : '0);
      e_wdata = e_cg ? core_wdata : (e_eg ? ext_wdata : '0);
      chk("core_gnt",    XLen'(core_gnt),    XLen'(e_cg));
      chk("ext_gnt",     XLen'(ext_gnt),     XLen'(e_eg));
      chk("core_stall",  XLen'(core_stall),  XLen'(core_req && !e_cg));
      chk("mem_req",     XLen'(mem_req),     XLen'(e_cg || e_eg));
      chk("mem_we",      XLen'(mem_we),      XLen'(e_we));
      chk("mem_addr",    mem_addr,           e_addr);
      chk("mem_wdata",   mem_wdata,          e_wdata);
      chk("core_rvalid", XLen'(core_rvalid), XLen'(pend_core));
      chk("ext_rvalid",  XLen'(ext_rvalid),  XLen'(pend_ext));
      chk("core_rdata",  core_rdata,         pend_core ? pend_data : '0);
      chk("ext_rdata",   ext_rdata,          pend_ext ? pend_data : '0);
      last_cg = e_cg;
      last_eg = e_eg;
   endtask

   // Advances the model across the clock edge using the decision from check_cycle.
   task automatic edge_cycle();
      logic wr;
      logic [XLen-1:0] a, d;
      @(posedge clk);
      wr = last_cg ? core_we : ext_we;
      a  = last_cg ? core_addr : ext_addr;
      d  = last_cg ? core_wdata : ext_wdata;
      pend_core = last_cg && !core_we;
      pend_ext  = last_eg && !ext_we;
      if ((last_cg || last_eg) && !wr) pend_data = ref_mem[a[5:2]];
      if ((last_cg || last_eg) && wr) ref_mem[a[5:2]] = d;
      if (!ext_req || last_eg) streak = 0;
      else if (last_cg && streak < MaxRun) streak++;
      #1;
   endtask

   task automatic applyStimulus(input bit cr, input bit cw, input logic [XLen-1:0] ca,
                                input logic [XLen-1:0] cd, input bit er, input bit ew,
                                input logic [XLen-1:0] ea, input logic [XLen-1:0] ed);
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      ext_req = er;  ext_we = ew;  ext_addr = ea;  ext_wdata = ed;
      check_cycle();
      edge_cycle();
   endtask

   task automatic checkResetOutputs();
      chk("rst_core_gnt",    XLen'(core_gnt),    '0);
      chk("rst_ext_gnt",     XLen'(ext_gnt),     '0);
      chk("rst_core_stall",  XLen'(core_stall),  XLen'(core_req));
      chk("rst_mem_req",     XLen'(mem_req),     '0);
      chk("rst_mem_we",      XLen'(mem_we),      '0);
      chk("rst_mem_addr",    mem_addr,           '0);
      chk("rst_mem_wdata",   mem_wdata,          '0);
      chk("rst_core_rvalid", XLen'(core_rvalid), '0);
      chk("rst_ext_rvalid",  XLen'(ext_rvalid),  '0);
      chk("rst_core_rdata",  core_rdata,         '0);
      chk("rst_ext_rdata",   ext_rdata,          '0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'hA5A5_0000 | XLen'(i * 32'h111);
         env_mem[i] = ref_mem[i];
      end
      ref_mem[4] = 32'hDEADBEEF;
      env_mem[4] = 32'hDEADBEEF;
      streak = 0; pend_core = 0; pend_ext = 0; pend_data = '0;
      last_cg = 0; last_eg = 0;

      // power-on reset with requests pending
      rst_ni = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = '0;
      ext_req = 1'b1;  ext_we = 1'b0;  ext_addr = 32'h4;  ext_wdata = '0;
      #3;
      checkResetOutputs();
      #4;
      rst_ni = 1'b1;
      core_req = 1'b0; ext_req = 1'b0;

      // core read of 0xDEADBEEF, granted on the first edge after release
      applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      // ext write with core idle, then read back through the core
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // both hold requests: core x4, ext, repeating
      for (int i = 0; i < 15; i++) applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h8, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // alternating core 0x0 / ext 0x4 reads back to back
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0);
         else            applyStimulus(0, 0, 0, 0, 1, 0, 32'h4, 0);
      end

      // ext alone for 10 cycles, then contention must still favour core
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 0, 32'h4, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // reset lands in the cycle a core read is granted, with run_cnt built up
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8;
      ext_req = 1'b0;
      check_cycle();
      #1 rst_ni = 1'b0;
      #1 checkResetOutputs();
      @(posedge clk);
      streak = 0; pend_core = 0; pend_ext = 0;
      #1 core_req = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 32'hC, 0, 1, 0, 32'h18, 0);

      // random traffic that honours hold-until-granted
      core_req = 0; ext_req = 0;
      for (int n = 0; n < 400; n++) begin
         if (!(core_req && !last_cg)) begin
            core_req   = ($urandom_range(0, 99) < 65);
            core_we    = $urandom_range(0, 1) == 1;
            core_addr  = XLen'($urandom_range(0, 15)) << 2;
            core_wdata = $urandom;
         end
         if (!(ext_req && !last_eg)) begin
            ext_req   = ($urandom_range(0, 99) < 55);
            ext_we    = $urandom_range(0, 1) == 1;
            ext_addr  = XLen'($urandom_range(0, 15)) << 2;
            ext_wdata = $urandom;
         end
         check_cycle();
         edge_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
